// File: rtl/dmem_lsu.sv
// dmem_lsu -- MEM-stage load/store initiator for the single-port data memory.
//   Stores are posted into a WB_DEPTH-entry write buffer and drained whenever the
//   memory port is not busy with a load read. Loads forward from the youngest
//   matching buffer entry (latency 1) or read memory in state RD (latency 2).
// Ports:
//   clock, reset (synchronous, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata : CPU request handshake
//   rsp_valid/rsp_rdata                           : load response (pulse / held data)
//   wb_empty                                      : no store still pending
//   d_we/d_addr/d_dataout/d_datain                : memory port (read data same cycle)
//   err                                           : out-of-bounds pulse
// Configuration:
//   DMEM_LSU_BOUNDS_EN : requests with req_addr >= DEPTH are accepted, never reach
//                        memory, loads return 0, err pulses the cycle after accept.
//                        Undefined: addresses pass through unchecked, err stays 0.
module dmem_lsu #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 64,
   parameter int WB_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              wb_empty,
   output logic              d_we,
   output logic [ADDR_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_dataout,
   input  logic [DATA_W-1:0] d_datain,
   output logic              err
);

   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

`ifdef DMEM_LSU_BOUNDS_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
   logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
   logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
   logic [DATA_W-1:0] wb_data_d [WB_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, iss_ptr;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              d_we_q, d_we_d;
   logic [ADDR_W-1:0] d_addr_q, d_addr_d;
   logic [DATA_W-1:0] d_dataout_q, d_dataout_d;
   logic              err_q, err_d;

   logic              wb_full, accept, oob, hit, push, pop, issue;
   logic [DATA_W-1:0] hit_data;

   assign wb_full   = (count_q == CNT_W'(WB_DEPTH));
   assign req_ready = (state_q == IDLE) && !wb_full;
   assign accept    = req_valid && req_ready;
   assign oob       = BOUNDS_EN && (int'(req_addr) >= DEPTH);

   // Youngest match wins: scan oldest -> youngest, later hits overwrite.
   // The entry currently on the port stays in the buffer until its write edge.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (CNT_W'(i) < count_q && wb_addr_q[rd_ptr_q + PTR_W'(i)] == req_addr) begin
            hit      = 1'b1;
            hit_data = wb_data_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      d_we_d      = 1'b0;
      d_addr_d    = d_addr_q;
      d_dataout_d = d_dataout_q;
      err_d       = 1'b0;
      push        = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (oob) begin
                  err_d = 1'b1;
                  if (!req_we) begin
                     rsp_valid_d = 1'b1;
                     rsp_rdata_d = '0;
                  end
               end else if (req_we) begin
                  push = 1'b1;
               end else if (hit) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = hit_data;
               end else begin
                  state_d  = RD;
                  d_addr_d = req_addr;
               end
            end
         end
         RD: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = d_datain;
            state_d     = IDLE;
         end
      endcase

      // The head entry is written while d_we_q is high and popped at that edge;
      // the next entry may be launched on the same edge so drains run back-to-back.
      pop     = d_we_q;
      iss_ptr = rd_ptr_q + PTR_W'(d_we_q);
      issue   = (state_d != RD) && (count_q > CNT_W'(d_we_q));
      if (issue) begin
         d_we_d      = 1'b1;
         d_addr_d    = wb_addr_q[iss_ptr];
         d_dataout_d = wb_data_q[iss_ptr];
      end

      if (push) begin
         wb_addr_d[wr_ptr_q] = req_addr;
         wb_data_d[wr_ptr_q] = req_wdata;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         d_we_q      <= 1'b0;
         d_addr_q    <= '0;
         d_dataout_q <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < WB_DEPTH; i++) begin
            wb_addr_q[i] <= '0;
            wb_data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         d_we_q      <= d_we_d;
         d_addr_q    <= d_addr_d;
         d_dataout_q <= d_dataout_d;
         err_q       <= err_d;
         wb_addr_q   <= wb_addr_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign wb_empty  = (count_q == '0);
   assign d_we      = d_we_q;
   assign d_addr    = d_addr_q;
   assign d_dataout = d_dataout_q;
   assign err       = err_q;

endmodule
